// File: rtl/pipe_if_pkg.sv
// Shared fetch-stage types: next-PC select codes,
// fetch FSM states and the IF/ID bundle.
package pipe_if_pkg;

  localparam logic [2:0] PC_SEL_PC4 = 3'd0;
  localparam logic [2:0] PC_SEL_B   = 3'd1;
  localparam logic [2:0] PC_SEL_J   = 3'd2;
  localparam logic [2:0] PC_SEL_R   = 3'd3;

  localparam logic [31:0] NOP_INSTR = 32'h0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    FULL = 2'd2
  } if_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } if_id_t;

endpackage

// File: rtl/if_skid_buf.sv
// One-entry holding register for a fetch response
// that arrives while decode is stalled.
module if_skid_buf
  import pipe_if_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   load_i,
  input  logic   drain_i,
  input  if_id_t data_i,
  output if_id_t data_o,
  output logic   full_o
);

  if_id_t data_q;
  logic   full_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else begin
      if (load_i) begin
        data_q <= data_i;
        full_q <= 1'b1;
      end else if (drain_i) begin
        full_q <= 1'b0;
      end
    end
  end

  assign data_o = data_q;
  assign full_o = full_q;

endmodule

// File: rtl/pipe_if.sv
// Instruction-fetch stage: fetch PC, single-outstanding
// imem requests, IF/ID register with skid, delayed redirects.
module pipe_if
  import pipe_if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic [2:0]  pc_mux_sel,
  input  logic        is_branch,
  input  logic [31:0] r_pc,
  input  logic [31:0] b_pc,
  input  logic [31:0] j_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_instruction,
  output logic [31:0] if_pc4,
  output logic        if_valid
);

  if_state_e   state_q;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] req_pc_q;
  logic [31:0] tgt_q, tgt_d;
  logic        pend_q, pend_d;
  logic [31:0] cap_tgt;
  logic        cap;
  logic        consume, ifid_load;
  logic        acc, reissue;
  logic        skid_full;
  if_id_t      skid_q, rsp;

  assign consume   = if_valid & ~stall;
  assign ifid_load = consume | ~if_valid;
  assign acc       = (state_q == WAIT) & imem_valid;
  assign reissue   = acc & ifid_load;

  assign rsp.instr = imem_rdata;
  assign rsp.pc4   = req_pc_q + 32'd4;

  always_comb begin
    cap     = 1'b0;
    cap_tgt = j_pc;
    if (consume) begin
      unique case (1'b1)
        (pc_mux_sel == PC_SEL_J): begin
          cap     = 1'b1;
          cap_tgt = j_pc;
        end
        (pc_mux_sel == PC_SEL_R): begin
          cap     = 1'b1;
          cap_tgt = r_pc;
        end
        (pc_mux_sel == PC_SEL_B): begin
          cap     = is_branch;
          cap_tgt = b_pc;
        end
        default: cap = 1'b0;
      endcase
    end
  end

  // Redirect takes effect on the fetch after the delay slot
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    pend_d     = pend_q;
    tgt_d      = tgt_q;
    if (acc) begin
      pend_d = 1'b0;
      if (cap)
        fetch_pc_d = cap_tgt;
      else if (pend_q)
        fetch_pc_d = tgt_q;
      else
        fetch_pc_d = fetch_pc_q + 32'd4;
    end else if (cap) begin
      pend_d = 1'b1;
      tgt_d  = cap_tgt;
      if (state_q == FULL)
        fetch_pc_d = cap_tgt;
    end else if (state_q == IDLE) begin
      pend_d = 1'b0;
    end
  end

  assign imem_req  = rst & ((state_q == IDLE) | reissue);
  assign imem_addr = reissue ? fetch_pc_d : fetch_pc_q;

  if_skid_buf u_skid (
    .clk     (clk),
    .rst_n   (rst),
    .load_i  (acc & ~ifid_load),
    .drain_i (skid_full & ifid_load),
    .data_i  (rsp),
    .data_o  (skid_q),
    .full_o  (skid_full)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      fetch_pc_q     <= RESET_PC;
      req_pc_q       <= RESET_PC;
      tgt_q          <= '0;
      pend_q         <= 1'b0;
      if_instruction <= NOP_INSTR;
      if_pc4         <= '0;
      if_valid       <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      pend_q     <= pend_d;
      tgt_q      <= tgt_d;
      if (imem_req)
        req_pc_q <= imem_addr;
      unique case (state_q)
        IDLE: state_q <= WAIT;
        WAIT: if (acc) state_q <= ifid_load ? WAIT : FULL;
        FULL: if (ifid_load) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
      if (ifid_load) begin
        if (skid_full) begin
          if_instruction <= skid_q.instr;
          if_pc4         <= skid_q.pc4;
          if_valid       <= 1'b1;
        end else if (acc) begin
          if_instruction <= rsp.instr;
          if_pc4         <= rsp.pc4;
          if_valid       <= 1'b1;
        end else begin
          if_instruction <= NOP_INSTR;
          if_valid       <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipe_if.sv
// Directed bench for pipe_if: streaming, stalls,
// delayed redirects, async reset and PC wrap.
module tb_pipe_if;
  import pipe_if_pkg::*;

  logic        clk, rst, stall, is_branch;
  logic [2:0]  pc_mux_sel;
  logic [31:0] r_pc, b_pc, j_pc;
  logic        imem_req, imem_valid, if_valid;
  logic [31:0] imem_addr, imem_rdata, if_instruction, if_pc4;

  logic        w_rst, w_req, w_valid, w_if_valid;
  logic [31:0] w_addr, w_rdata, w_instr, w_pc4;

  int tests = 0;
  int fails = 0;

  int          lat;
  logic        m_busy, m_rq, w_s_req;
  int          m_cnt;
  logic [31:0] m_addr, m_ra, w_s_addr;
  logic        br_en, br_taken, dec;
  logic [2:0]  br_sel;
  logic [31:0] br_pc4;

  pipe_if dut (
    .clk(clk), .rst(rst), .stall(stall),
    .pc_mux_sel(pc_mux_sel), .is_branch(is_branch),
    .r_pc(r_pc), .b_pc(b_pc), .j_pc(j_pc),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata),
    .if_instruction(if_instruction), .if_pc4(if_pc4),
    .if_valid(if_valid)
  );

  pipe_if #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(w_rst), .stall(1'b0),
    .pc_mux_sel(PC_SEL_PC4), .is_branch(1'b0),
    .r_pc(32'h0), .b_pc(32'h0), .j_pc(32'h0),
    .imem_req(w_req), .imem_addr(w_addr),
    .imem_valid(w_valid), .imem_rdata(w_rdata),
    .if_instruction(w_instr), .if_pc4(w_pc4),
    .if_valid(w_if_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  // memory with configurable latency plus a one-instruction decode
  always @(posedge clk) begin
    m_rq = imem_req;
    m_ra = imem_addr;
    #1;
    imem_valid = 1'b0;
    if (!rst) begin
      m_busy = 1'b0;
    end else begin
      if (m_rq) begin
        m_busy = 1'b1;
        m_addr = m_ra;
        m_cnt  = lat;
      end
      if (m_busy) begin
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) begin
          imem_valid = 1'b1;
          imem_rdata = word(m_addr);
          m_busy     = 1'b0;
        end
      end
    end
    dec        = br_en && if_valid && (if_pc4 == br_pc4);
    pc_mux_sel = dec ? br_sel : PC_SEL_PC4;
    is_branch  = dec && br_taken;
  end

  always @(posedge clk) begin
    w_s_req  = w_req;
    w_s_addr = w_addr;
    #1;
    w_valid = w_s_req & w_rst;
    w_rdata = word(w_s_addr);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input int l);
    lat = l;
    br_en = 1'b0;
    stall = 1'b0;
    rst = 1'b0;
    step(2);
    rst = 1'b1;
    #1;
  endtask

  task automatic test_reset;
    lat = 1;
    rst = 1'b0;
    step(2);
    tests++;
    if ({imem_req, imem_addr} !== {1'b0, 32'h0040_0000}) begin
      fails++;
      $display("FAIL reset_req: got %h want %h", {imem_req, imem_addr}, {1'b0, 32'h0040_0000});
    end
    tests++;
    if ({if_valid, if_instruction, if_pc4} !== 65'h0) begin
      fails++;
      $display("FAIL reset_ifid: got %h want 0", {if_valid, if_instruction, if_pc4});
    end
    rst = 1'b1;
    #1;
    tests++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h0040_0000}) begin
      fails++;
      $display("FAIL first_req: got %h want %h", {imem_req, imem_addr}, {1'b1, 32'h0040_0000});
    end
    step(1);
    tests++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h0040_0004}) begin
      fails++;
      $display("FAIL reissue: got %h want %h", {imem_req, imem_addr}, {1'b1, 32'h0040_0004});
    end
  endtask

  task automatic test_stream;
    logic [31:0] e;
    do_reset(1);
    step(2);
    for (int i = 0; i < 6; i++) begin
      e = 32'h0040_0004 + 32'(4 * i);
      tests++;
      if ({if_valid, if_pc4, if_instruction} !== {1'b1, e, word(e - 32'd4)}) begin
        fails++;
        $display("FAIL stream[%0d]: got %h want %h", i, {if_valid, if_pc4, if_instruction}, {1'b1, e, word(e - 32'd4)});
      end
      step(1);
    end
  endtask

  task automatic test_stall;
    do_reset(1);
    step(4);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++;
      if ({if_valid, if_pc4, imem_req} !== {1'b1, 32'h0040_000C, 1'b0}) begin
        fails++;
        $display("FAIL stall_hold[%0d]: got %h want %h", i, {if_valid, if_pc4, imem_req}, {1'b1, 32'h0040_000C, 1'b0});
      end
      step(1);
    end
    stall = 1'b0;
    step(1);
    tests++;
    if ({if_valid, if_pc4, if_instruction} !== {1'b1, 32'h0040_0010, word(32'h0040_000C)}) begin
      fails++;
      $display("FAIL stall_skid: got %h want %h", {if_valid, if_pc4, if_instruction}, {1'b1, 32'h0040_0010, word(32'h0040_000C)});
    end
    tests++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h0040_0010}) begin
      fails++;
      $display("FAIL stall_resume: got %h want %h", {imem_req, imem_addr}, {1'b1, 32'h0040_0010});
    end
    step(1);
    tests++;
    if ({if_valid, if_instruction} !== 33'h0) begin
      fails++;
      $display("FAIL stall_bubble: got %h want 0", {if_valid, if_instruction});
    end
    step(1);
    tests++;
    if ({if_valid, if_pc4} !== {1'b1, 32'h0040_0014}) begin
      fails++;
      $display("FAIL stall_next: got %h want %h", {if_valid, if_pc4}, {1'b1, 32'h0040_0014});
    end
  endtask

  task automatic test_branch(input logic [2:0] sel, input logic taken,
                             input logic [31:0] a5, input logic [31:0] p7);
    do_reset(1);
    br_en = 1'b1;
    br_pc4 = 32'h0040_0010;
    br_sel = sel;
    br_taken = taken;
    b_pc = 32'h0040_0100;
    j_pc = 32'h00AA_0000;
    r_pc = 32'h00BB_0000;
    step(5);
    tests++;
    if ({if_pc4, imem_req, imem_addr} !== {32'h0040_0010, 1'b1, a5}) begin
      fails++;
      $display("FAIL br_issue sel=%0d t=%0d: got %h want %h", sel, taken, {if_pc4, imem_req, imem_addr}, {32'h0040_0010, 1'b1, a5});
    end
    step(1);
    tests++;
    if ({if_valid, if_pc4} !== {1'b1, 32'h0040_0014}) begin
      fails++;
      $display("FAIL br_slot sel=%0d t=%0d: got %h want %h", sel, taken, {if_valid, if_pc4}, {1'b1, 32'h0040_0014});
    end
    step(1);
    tests++;
    if ({if_valid, if_pc4, if_instruction} !== {1'b1, p7, word(p7 - 32'd4)}) begin
      fails++;
      $display("FAIL br_next sel=%0d t=%0d: got %h want %h", sel, taken, {if_valid, if_pc4, if_instruction}, {1'b1, p7, word(p7 - 32'd4)});
    end
  endtask

  task automatic test_jr_lat3;
    do_reset(3);
    br_en = 1'b1;
    br_pc4 = 32'h0040_0008;
    br_sel = PC_SEL_R;
    br_taken = 1'b0;
    r_pc = 32'h0040_0200;
    b_pc = 32'h00AA_0000;
    j_pc = 32'h00BB_0000;
    step(7);
    tests++;
    if ({if_valid, if_pc4, imem_req} !== {1'b1, 32'h0040_0008, 1'b0}) begin
      fails++;
      $display("FAIL jr_capture: got %h want %h", {if_valid, if_pc4, imem_req}, {1'b1, 32'h0040_0008, 1'b0});
    end
    step(1);
    tests++;
    if ({if_valid, if_instruction} !== 33'h0) begin
      fails++;
      $display("FAIL jr_bubble1: got %h want 0", {if_valid, if_instruction});
    end
    step(1);
    tests++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h0040_0200}) begin
      fails++;
      $display("FAIL jr_target: got %h want %h", {imem_req, imem_addr}, {1'b1, 32'h0040_0200});
    end
    step(1);
    tests++;
    if ({if_valid, if_pc4, if_instruction} !== {1'b1, 32'h0040_000C, word(32'h0040_0008)}) begin
      fails++;
      $display("FAIL jr_slot: got %h want %h", {if_valid, if_pc4, if_instruction}, {1'b1, 32'h0040_000C, word(32'h0040_0008)});
    end
    step(1);
    tests++;
    if ({if_valid, if_instruction} !== 33'h0) begin
      fails++;
      $display("FAIL jr_bubble2: got %h want 0", {if_valid, if_instruction});
    end
    step(2);
    tests++;
    if ({if_valid, if_pc4, if_instruction} !== {1'b1, 32'h0040_0204, word(32'h0040_0200)}) begin
      fails++;
      $display("FAIL jr_dest: got %h want %h", {if_valid, if_pc4, if_instruction}, {1'b1, 32'h0040_0204, word(32'h0040_0200)});
    end
  endtask

  task automatic test_full_redirect;
    do_reset(1);
    br_en = 1'b1;
    br_pc4 = 32'h0040_000C;
    br_sel = PC_SEL_J;
    br_taken = 1'b0;
    j_pc = 32'h0040_0300;
    b_pc = 32'h00AA_0000;
    r_pc = 32'h00BB_0000;
    step(4);
    stall = 1'b1;
    step(3);
    stall = 1'b0;
    step(1);
    tests++;
    if ({if_valid, if_pc4, imem_req, imem_addr} !== {1'b1, 32'h0040_0010, 1'b1, 32'h0040_0300}) begin
      fails++;
      $display("FAIL full_j_issue: got %h want %h", {if_valid, if_pc4, imem_req, imem_addr}, {1'b1, 32'h0040_0010, 1'b1, 32'h0040_0300});
    end
    step(1);
    tests++;
    if ({if_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h0040_0304}) begin
      fails++;
      $display("FAIL full_j_seq: got %h want %h", {if_valid, imem_req, imem_addr}, {1'b0, 1'b1, 32'h0040_0304});
    end
    step(1);
    tests++;
    if ({if_valid, if_pc4, if_instruction} !== {1'b1, 32'h0040_0304, word(32'h0040_0300)}) begin
      fails++;
      $display("FAIL full_j_dest: got %h want %h", {if_valid, if_pc4, if_instruction}, {1'b1, 32'h0040_0304, word(32'h0040_0300)});
    end
    step(1);
    tests++;
    if ({if_valid, if_pc4} !== {1'b1, 32'h0040_0308}) begin
      fails++;
      $display("FAIL full_j_after: got %h want %h", {if_valid, if_pc4}, {1'b1, 32'h0040_0308});
    end
  endtask

  task automatic test_rst_mid;
    do_reset(3);
    step(4);
    rst = 1'b0;
    #1;
    tests++;
    if ({imem_req, imem_addr, if_valid, if_instruction, if_pc4} !== {1'b0, 32'h0040_0000, 65'h0}) begin
      fails++;
      $display("FAIL rst_async: got %h want %h", {imem_req, imem_addr, if_valid, if_instruction, if_pc4}, {1'b0, 32'h0040_0000, 65'h0});
    end
    step(2);
    rst = 1'b1;
    #1;
    tests++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h0040_0000}) begin
      fails++;
      $display("FAIL rst_restart: got %h want %h", {imem_req, imem_addr}, {1'b1, 32'h0040_0000});
    end
    step(4);
    tests++;
    if ({if_valid, if_pc4, if_instruction} !== {1'b1, 32'h0040_0004, word(32'h0040_0000)}) begin
      fails++;
      $display("FAIL rst_first: got %h want %h", {if_valid, if_pc4, if_instruction}, {1'b1, 32'h0040_0004, word(32'h0040_0000)});
    end
  endtask

  task automatic test_wrap;
    step(1);
    w_rst = 1'b1;
    #1;
    tests++;
    if ({w_req, w_addr} !== {1'b1, 32'hFFFF_FFFC}) begin
      fails++;
      $display("FAIL wrap_first: got %h want %h", {w_req, w_addr}, {1'b1, 32'hFFFF_FFFC});
    end
    step(1);
    tests++;
    if ({w_req, w_addr} !== {1'b1, 32'h0}) begin
      fails++;
      $display("FAIL wrap_second: got %h want %h", {w_req, w_addr}, {1'b1, 32'h0});
    end
    step(1);
    tests++;
    if ({w_if_valid, w_pc4, w_instr} !== {1'b1, 32'h0, word(32'hFFFF_FFFC)}) begin
      fails++;
      $display("FAIL wrap_pc4: got %h want %h", {w_if_valid, w_pc4, w_instr}, {1'b1, 32'h0, word(32'hFFFF_FFFC)});
    end
    step(1);
    tests++;
    if ({w_if_valid, w_pc4} !== {1'b1, 32'h4}) begin
      fails++;
      $display("FAIL wrap_next: got %h want %h", {w_if_valid, w_pc4}, {1'b1, 32'h4});
    end
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b0;
    w_rst = 1'b0;
    stall = 1'b0;
    lat = 1;
    m_busy = 1'b0;
    m_cnt = 0;
    m_addr = '0;
    br_en = 1'b0;
    br_taken = 1'b0;
    br_sel = PC_SEL_PC4;
    br_pc4 = '0;
    pc_mux_sel = PC_SEL_PC4;
    is_branch = 1'b0;
    r_pc = '0;
    b_pc = '0;
    j_pc = '0;
    imem_valid = 1'b0;
    imem_rdata = '0;
    w_valid = 1'b0;
    w_rdata = '0;
    test_reset();
    test_stream();
    test_stall();
    test_branch(PC_SEL_B, 1'b1, 32'h0040_0100, 32'h0040_0104);
    test_branch(PC_SEL_B, 1'b0, 32'h0040_0014, 32'h0040_0018);
    test_branch(3'd5, 1'b1, 32'h0040_0014, 32'h0040_0018);
    test_jr_lat3();
    test_full_redirect();
    test_rst_mid();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipe_if.md
Name: pipe_if

Overview:
- Instruction-fetch stage of the static five-stage pipeline, directly upstream of the decode stage.
- Owns the fetch PC and issues word fetches to the instruction memory, with one request outstanding at a time.
- Holds the IF/ID pipeline register that feeds decode (instruction, pc4, valid), with a one-entry skid buffer to absorb decode stalls.
- Applies jump, branch and jr redirects from decode after the single architectural delay slot.

Parameters:
RESET_PC, 32'h0040_0000, address of the first fetch after reset.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset; asynchronous, active-low.
stall  in  1  decode hazard stall; decode holds its instruction this cycle.
pc_mux_sel  in  3  next-PC select from decode control.
is_branch  in  1  decode branch-compare result (beq/bne taken).
r_pc  in  32  jr/jalr target (rs data).
b_pc  in  32  branch target.
j_pc  in  32  j/jal target.
imem_req  out  1  single-cycle fetch request; memory always accepts.
imem_addr  out  32  word address of the request; valid while imem_req=1.
imem_valid  in  1  response strobe; at least 1 cycle after the request; at most one per request.
imem_rdata  in  32  instruction word; valid with imem_valid.
if_instruction  out  32  IF/ID instruction to decode; 32'h0 (NOP) when if_valid=0.
if_pc4  out  32  IF/ID PC+4 of if_instruction.
if_valid  out  1  IF/ID holds a real instruction.

Behaviour:
- Reset (rst=0, async):
  - fetch_pc=RESET_PC; state=IDLE.
  - imem_req=0, imem_addr=RESET_PC.
  - if_valid=0, if_instruction=0, if_pc4=0.
  - Skid buffer empty; redirect pending cleared.
- Outputs: all outputs are registered except imem_req/imem_addr, which decode from state and fetch_pc.
- Consume: consume = if_valid & ~stall. In a consume cycle, decode takes IF/ID.
- IF/ID load source, in priority order:
  - skid entry if skid full;
  - else the arriving response (imem_valid);
  - else a bubble (if_valid=0, if_instruction=0).
- IF/ID update rule:
  - IF/ID loads when consume=1 or if_valid=0.
  - Otherwise IF/ID holds, and an arriving response goes to skid.
- FSM:
  - IDLE: imem_req=1, imem_addr=fetch_pc; req_pc<=fetch_pc; goto WAIT.
  - WAIT: imem_req=0 until imem_valid. On imem_valid, the response is accepted into IF/ID or skid.
    - If it went to IF/ID, the same cycle re-issues (imem_req=1 at the new fetch_pc) and stays in WAIT. This gives one instruction per cycle at latency 1.
    - If it went to skid, goto FULL with no issue.
  - FULL: no requests. When the skid drains into IF/ID, goto IDLE.
- Returned instruction tag: if_pc4 = req_pc + 4, modulo 2^32, wrapping from 32'hFFFF_FFFC to 0.
- Fetch-PC advance: on each accepted response, fetch_pc <= redirect_pending ? redirect_target : fetch_pc + 4; redirect_pending is then cleared.
  - Same-cycle issue (WAIT re-issue) uses the advanced value combinationally.
- Redirect capture occurs when consume=1 and one of:
  - pc_mux_sel=PC_SEL_J: target j_pc;
  - pc_mux_sel=PC_SEL_R: target r_pc;
  - pc_mux_sel=PC_SEL_B and is_branch=1: target b_pc.
  - PC_SEL_PC4, reserved codes, and untaken branches are not redirects.
- Delay slot:
  - When a redirect is captured, the delay-slot fetch (branch pc4) has already been issued or returned. It is never squashed.
  - The target is the address fetched immediately after the delay slot.
- Redirect timing cases:
  - Delay-slot response accepted in the same cycle as capture: fetch_pc takes the target directly, bypassing the pending register.
  - Delay slot already accepted before capture (sitting in skid, or in FULL): redirect_pending<=1 and fetch_pc<=target. The next IDLE issue uses the target.
- stall=1 with if_valid=1: IF/ID holds exactly. At most one response is buffered, in skid. No redirect is captured.
- Reset mid-transaction: an in-flight response is abandoned. Any imem_valid arriving after reset release in IDLE is ignored; the memory model must not deliver it.

Decomposition:
- Shared package constants PC_SEL_PC4=3'd0, PC_SEL_B=3'd1, PC_SEL_J=3'd2, PC_SEL_R=3'd3 (4-7 reserved, treated as PC4), shared with control_unit.
- Shared package also holds the FSM state encoding IDLE/WAIT/FULL and NOP_INSTR=32'h0.
- One sub-module: if_skid_buf, a 1-entry 64-bit {instr, pc4} holding register with full flag and load/drain controls.

Test Plan:
- Reset, then latency-1 memory returning addr-derived words → first imem_req at 0x00400000 in the first cycle after rst rises. Thereafter one request per cycle; if_pc4 = 0x00400004, 0x00400008, … with if_valid continuous.
- stall=1 for 3 cycles while streaming → IF/ID held constant; skid captures one word; imem_req=0 while in FULL. After release, the skid word appears next, then issue resumes with no lost or duplicated pc4.
- Branch in IF/ID with if_pc4=0x00400010, pc_mux_sel=PC_SEL_B, is_branch=1, b_pc=0x00400100 → next two if_pc4 = 0x00400014 (delay slot), then 0x00400104. Repeat with is_branch=0 → sequential 0x00400018.
- Latency-3 memory; jr captured (r_pc=0x00400200) while the delay-slot fetch is outstanding → delay slot delivered, next imem_addr=0x00400200, and if_valid=0 bubbles carry if_instruction=0 in between.
- Redirect captured while FULL with delay slot in skid → redirect_pending set; after drain, IDLE issues j_pc.
- rst pulled low mid-WAIT → all outputs reach reset values asynchronously; after release, the first request is at RESET_PC; Wrap: RESET_PC=32'hFFFF_FFFC → second imem_addr=0 and first if_pc4=0.
